// File: rtl/pixel_stream_reader.sv
`default_nettype none
// ============================================================================
//  Module   : pixel_stream_reader
//  Purpose  : Reads a complete frame out of the frame RAM, addresses
//             0..RAM_DEPTH-1. It emits the pixels as a gap-free stream with
//             enable and last markers. The RAM read latency is hidden by a
//             valid/last shift register that follows each issued address.
//             A one-cycle done pulse follows the final pixel.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Parameters
//    DATA_WIDTH  pixel width
//    RAM_DEPTH   pixels per frame (need not be a power of two)
//    ADDR_WIDTH  RAM address width
//    RD_LATENCY  RAM read latency in cycles, legal range 1..4
//  Ports
//    clk_i_reader       in   clock
//    rstn_i_reader      in   synchronous active-low reset
//    start_i_reader     in   start a frame scan (sampled in IDLE only)
//    ram_en_o_reader    out  RAM read enable
//    ram_addr_o_reader  out  RAM read address
//    ram_data_i_reader  in   RAM read data, RD_LATENCY cycles after address
//    data_o_reader      out  registered pixel (0 whenever en is low)
//    en_o_reader        out  pixel valid, contiguous for the whole frame
//    last_o_reader      out  marks the final pixel
//    busy_o_reader      out  scan in progress (ISSUE, DRAIN, DONE)
//    done_o_reader      out  one-cycle completion pulse
//  Build option
//    READER_PREAMBLE_EN  when defined, en is also raised for one cycle
//                        (data 0, last 0) directly before pixel 0
// ============================================================================
module pixel_stream_reader #(
  parameter int DATA_WIDTH = 8,
  parameter int RAM_DEPTH  = 76800,
  parameter int ADDR_WIDTH = $clog2(RAM_DEPTH),
  parameter int RD_LATENCY = 1
) (
  input  logic                  clk_i_reader,
  input  logic                  rstn_i_reader,
  input  logic                  start_i_reader,
  output logic                  ram_en_o_reader,
  output logic [ADDR_WIDTH-1:0] ram_addr_o_reader,
  input  logic [DATA_WIDTH-1:0] ram_data_i_reader,
  output logic [DATA_WIDTH-1:0] data_o_reader,
  output logic                  en_o_reader,
  output logic                  last_o_reader,
  output logic                  busy_o_reader,
  output logic                  done_o_reader
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  // Full-width terminal address, so that non-power-of-two depths stop exactly.
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(RAM_DEPTH - 1);

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic                    ram_en_q, ram_en_d;

  // Stage i is high in the cycle i+1 after an address was issued, so the
  // top stage lines up with the RAM data for that address.
  logic [RD_LATENCY-1:0]   vld_q, vld_d;
  logic [RD_LATENCY-1:0]   lst_q, lst_d;

  logic [DATA_WIDTH-1:0]   data_q, data_d;
  logic                    en_q, en_d;
  logic                    last_q, last_d;

  logic                    addr_at_end;
  logic                    pipe_busy;
  logic                    start_accept;

  assign addr_at_end  = (addr_q == LAST_ADDR);
  assign pipe_busy    = |vld_q;
  assign start_accept = (state_q == S_IDLE) && start_i_reader;

  // --------------------------------------------------------------------------
  // Next-state logic and address counter
  // --------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    ram_en_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_i_reader) begin
          state_d  = S_ISSUE;
          addr_d   = '0;
          ram_en_d = 1'b1;
        end
      end
      S_ISSUE: begin
        // The terminal address is currently on the bus. Stop issuing and
        // hold the address.
        if (addr_at_end) begin
          state_d = S_DRAIN;
        end else begin
          addr_d   = addr_q + 1'b1;
          ram_en_d = 1'b1;
        end
      end
      S_DRAIN: begin
        // Once the pipeline is empty, the final pixel sits in the output
        // register this cycle, so done lands in the following cycle.
        if (!pipe_busy) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Read-latency compensation pipeline and output register
  // --------------------------------------------------------------------------
  always_comb begin
    vld_d    = '0;
    lst_d    = '0;
    vld_d[0] = ram_en_q;
    lst_d[0] = ram_en_q && addr_at_end;
    for (int i = 1; i < RD_LATENCY; i++) begin
      vld_d[i] = vld_q[i-1];
      lst_d[i] = lst_q[i-1];
    end
  end

`ifdef READER_PREAMBLE_EN
  // Marks the accepted start and travels RD_LATENCY stages. On exit it raises
  // en one cycle ahead of pixel 0.
  logic [RD_LATENCY-1:0] pre_q, pre_d;

  always_comb begin
    pre_d    = '0;
    pre_d[0] = start_accept;
    for (int i = 1; i < RD_LATENCY; i++) begin
      pre_d[i] = pre_q[i-1];
    end
  end

  always_ff @(posedge clk_i_reader) begin
    if (!rstn_i_reader) begin
      pre_q <= '0;
    end else begin
      pre_q <= pre_d;
    end
  end

  assign en_d = vld_q[RD_LATENCY-1] || pre_q[RD_LATENCY-1];
`else
  // Without the preamble, the accepted start has no use beyond the FSM.
  logic unused_start_accept;
  assign unused_start_accept = start_accept;

  assign en_d = vld_q[RD_LATENCY-1];
`endif

  // Data is forced to zero whenever no pixel is valid. This includes the
  // preamble cycle.
  assign data_d = vld_q[RD_LATENCY-1] ? ram_data_i_reader : '0;
  assign last_d = lst_q[RD_LATENCY-1];

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i_reader) begin
    if (!rstn_i_reader) begin
      state_q  <= S_IDLE;
      addr_q   <= '0;
      ram_en_q <= 1'b0;
      vld_q    <= '0;
      lst_q    <= '0;
      data_q   <= '0;
      en_q     <= 1'b0;
      last_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      ram_en_q <= ram_en_d;
      vld_q    <= vld_d;
      lst_q    <= lst_d;
      data_q   <= data_d;
      en_q     <= en_d;
      last_q   <= last_d;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign ram_en_o_reader   = ram_en_q;
  assign ram_addr_o_reader = addr_q;
  assign data_o_reader     = data_q;
  assign en_o_reader       = en_q;
  assign last_o_reader     = last_q;
  assign busy_o_reader     = (state_q != S_IDLE);
  assign done_o_reader     = (state_q == S_DONE);

endmodule
`default_nettype wire

// File: tb/tb_pixel_stream_reader.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pixel_stream_reader
//  Purpose  : Self-checking bench for pixel_stream_reader. It drives two
//             instances from one start/reset pair:
//               A: RAM_DEPTH=16, RD_LATENCY=1
//               B: RAM_DEPTH=10, RD_LATENCY=3
//             Each instance is compared every cycle against a frame-timeline
//             model. The model knows only the relative cycle within a frame.
//             Honours READER_PREAMBLE_EN when defined.
//  Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_pixel_stream_reader;

  localparam int DW  = 8;
  localparam int DA  = 16;
  localparam int LA  = 1;
  localparam int AWA = 4;
  localparam int DB  = 10;
  localparam int LB  = 3;
  localparam int AWB = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rstn;
  logic start;

  logic           ram_en_a, en_a, last_a, busy_a, done_a;
  logic [AWA-1:0] addr_a;
  logic [DW-1:0]  rdata_a, data_a;
  logic           ram_en_b, en_b, last_b, busy_b, done_b;
  logic [AWB-1:0] addr_b;
  logic [DW-1:0]  rdata_b, data_b;

  pixel_stream_reader #(
    .DATA_WIDTH(DW), .RAM_DEPTH(DA), .ADDR_WIDTH(AWA), .RD_LATENCY(LA)
  ) dut_a (
    .clk_i_reader(clk), .rstn_i_reader(rstn), .start_i_reader(start),
    .ram_en_o_reader(ram_en_a), .ram_addr_o_reader(addr_a),
    .ram_data_i_reader(rdata_a), .data_o_reader(data_a),
    .en_o_reader(en_a), .last_o_reader(last_a),
    .busy_o_reader(busy_a), .done_o_reader(done_a)
  );

  pixel_stream_reader #(
    .DATA_WIDTH(DW), .RAM_DEPTH(DB), .ADDR_WIDTH(AWB), .RD_LATENCY(LB)
  ) dut_b (
    .clk_i_reader(clk), .rstn_i_reader(rstn), .start_i_reader(start),
    .ram_en_o_reader(ram_en_b), .ram_addr_o_reader(addr_b),
    .ram_data_i_reader(rdata_b), .data_o_reader(data_b),
    .en_o_reader(en_b), .last_o_reader(last_b),
    .busy_o_reader(busy_b), .done_o_reader(done_b)
  );

  // Behavioural RAMs. Junk is returned when the RAM is not enabled.
  logic [DW-1:0] mem_a [0:15];
  logic [DW-1:0] mem_b [0:15];
  logic [DW-1:0] pipe_b [0:LB-1];

  always @(posedge clk) begin
    rdata_a <= ram_en_a ? mem_a[addr_a] : DW'($urandom);
  end

  always @(posedge clk) begin
    pipe_b[0] <= ram_en_b ? mem_b[addr_b] : DW'($urandom);
    for (int i = 1; i < LB; i++) pipe_b[i] <= pipe_b[i-1];
  end
  assign rdata_b = pipe_b[LB-1];

  // Reference model state. act: a frame is in progress. n: cycle number
  // within the frame (1 = first issue cycle). hold: expected address bus.
  int checks = 0;
  int errors = 0;
  int act_a = 0, n_a = 0, hold_a = 0;
  int act_b = 0, n_b = 0, hold_b = 0;
  int dones_a = 0, exp_dones_a = 0;
  int dones_b = 0, exp_dones_b = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // A frame occupies cycles 1..d+l+2. Addresses are issued in 1..d and
  // pixels appear in 2+l..d+1+l. Done comes at d+l+2. Start counts only
  // while idle.
  task automatic model_adv(input int d, input int l, inout int act, inout int n, inout int hold);
    if (!rstn) begin
      act = 0; n = 0; hold = 0;
    end else if (act != 0) begin
      if (n == d + l + 2) begin act = 0; n = 0; end
      else n++;
    end else if (start) begin
      act = 1; n = 1;
    end
    if (act != 0) hold = (n <= d) ? n - 1 : d - 1;
  endtask

  task automatic check_inst(input string nm, input int d, input int l,
                            input int act, input int n, input int hold,
                            input logic [DW-1:0] pix,
                            input logic ram_en, input logic [31:0] addr,
                            input logic [DW-1:0] data, input logic en,
                            input logic last, input logic busy, input logic done);
    bit on;
    bit pix_on;
    bit pre_on;
    on     = (act != 0);
    pix_on = on && (n >= 2 + l) && (n <= d + 1 + l);
    pre_on = 1'b0;
`ifdef READER_PREAMBLE_EN
    pre_on = on && (n == 1 + l);
`endif
    chk({nm, ".busy"},   busy,   on);
    chk({nm, ".done"},   done,   on && (n == d + l + 2));
    chk({nm, ".ram_en"}, ram_en, on && (n <= d));
    chk({nm, ".addr"},   addr,   hold);
    chk({nm, ".en"},     en,     pix_on || pre_on);
    chk({nm, ".last"},   last,   on && (n == d + 1 + l));
    chk({nm, ".data"},   data,   pix_on ? pix : '0);
  endtask

  task automatic step();
    int k;
    logic [DW-1:0] pa, pb;
    @(posedge clk);
    model_adv(DA, LA, act_a, n_a, hold_a);
    model_adv(DB, LB, act_b, n_b, hold_b);
    @(negedge clk);
    k  = n_a - 2 - LA;
    pa = (act_a != 0 && k >= 0 && k < DA) ? mem_a[k] : '0;
    k  = n_b - 2 - LB;
    pb = (act_b != 0 && k >= 0 && k < DB) ? mem_b[k] : '0;
    check_inst("A", DA, LA, act_a, n_a, hold_a, pa,
               ram_en_a, 32'(addr_a), data_a, en_a, last_a, busy_a, done_a);
    check_inst("B", DB, LB, act_b, n_b, hold_b, pb,
               ram_en_b, 32'(addr_b), data_b, en_b, last_b, busy_b, done_b);
    if (done_a === 1'b1) dones_a++;
    if (done_b === 1'b1) dones_b++;
    if (act_a != 0 && n_a == DA + LA + 2) exp_dones_a++;
    if (act_b != 0 && n_b == DB + LB + 2) exp_dones_b++;
  endtask

  task automatic fill_mems();
    for (int i = 0; i < 16; i++) begin
      mem_a[i] = DW'($urandom);
      mem_b[i] = DW'($urandom);
    end
  endtask

  initial begin
    rstn  = 1'b0;
    start = 1'b0;
    fill_mems();

    // Reset state.
    repeat (3) step();
    rstn = 1'b1;
    repeat (2) step();

    // Single start pulse, then let both frames complete.
    start = 1'b1; step(); start = 1'b0;
    repeat (30) step();

    // Start held high: back-to-back frames. Start is ignored while busy.
    start = 1'b1;
    repeat (45) step();
    start = 1'b0;
    repeat (25) step();

    // Abort frame A at pixel 7 (cycle 10) with reset.
    start = 1'b1; step(); start = 1'b0;
    repeat (9) step();
    chk("A.pixel7_data", data_a, mem_a[7]);
    chk("A.pixel7_en",   en_a,   1'b1);
    rstn = 1'b0; step(); rstn = 1'b1;
    repeat (3) step();

    // Full frame from address 0 after the abort.
    start = 1'b1; step(); start = 1'b0;
    repeat (30) step();

    // Randomized start/reset traffic on fresh RAM contents.
    fill_mems();
    for (int i = 0; i < 200; i++) begin
      start = ($urandom_range(0, 7) == 0);
      rstn  = ($urandom_range(0, 59) != 0);
      step();
    end
    start = 1'b0;
    rstn  = 1'b1;
    repeat (30) step();

    chk("A.done_count", dones_a, exp_dones_a);
    chk("B.done_count", dones_b, exp_dones_b);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pixel_stream_reader.md
# pixel_stream_reader

Streams a full frame out of the frame RAM as a gap-free pixel stream with enable and last markers. It is the transmitting end of the pixel-stream interface consumed by the contrast-stretching statistics and mapping stages. On each start it scans RAM addresses 0..RAM_DEPTH-1 and compensates for the RAM read latency. It reports completion with a single-cycle done pulse.

## Interface
- DATA_WIDTH, 8, pixel width
- RAM_DEPTH, 76800, pixels per frame (320x240)
- ADDR_WIDTH, $clog2(RAM_DEPTH), RAM address width
- RD_LATENCY, 1, RAM read latency in cycles; legal range 1..4

Ports:
- clk_i_reader  in  1  clock
- rstn_i_reader  in  1  reset; one clock, reset synchronous, active-low
- start_i_reader  in  1  start a frame scan; sampled only in IDLE
- ram_en_o_reader  out  1  RAM read enable
- ram_addr_o_reader  out  ADDR_WIDTH  RAM read address
- ram_data_i_reader  in  DATA_WIDTH  RAM read data, valid RD_LATENCY cycles after the address
- data_o_reader  out  DATA_WIDTH  pixel out, registered
- en_o_reader  out  1  pixel valid; contiguous for the whole frame
- last_o_reader  out  1  high with the final pixel only
- busy_o_reader  out  1  scan in progress
- done_o_reader  out  1  one-cycle completion pulse

## Operation
- The FSM has four states.
  - IDLE -> ISSUE on start_i_reader=1.
  - ISSUE -> DRAIN after the address RAM_DEPTH-1 is issued.
  - DRAIN -> DONE once the valid pipeline is empty.
  - DONE -> IDLE unconditionally.
- ISSUE:
  - ram_en_o_reader=1 every cycle.
  - The address counter starts at 0 and increments by 1 per cycle. There are no stalls and no wrap. The counter stops at RAM_DEPTH-1.
- A valid/last shift register of depth RD_LATENCY follows each issued address.
  - On the RAM data return, the data is registered into data_o_reader, together with en_o_reader and last_o_reader.
  - last is tagged on the address equal to RAM_DEPTH-1.
- DRAIN: ram_en_o_reader=0 and the address is held. The state waits until the last pixel has left the output register.
- DONE: done_o_reader=1 for exactly one cycle. en_o_reader=0.
- busy_o_reader=1 in ISSUE, DRAIN and DONE; 0 in IDLE.
- start_i_reader is ignored outside IDLE and is not queued.
- The address counter compares against RAM_DEPTH-1 at full ADDR_WIDTH. Non-power-of-two depths must terminate exactly at RAM_DEPTH-1.
- When en_o_reader=0, data_o_reader is 0.
- Reset (rstn_i_reader=0 on a clock edge) takes priority over everything, including a scan in progress. It has the following effect:
  - FSM goes to IDLE.
  - Counter and valid pipeline are cleared.
  - All outputs go to 0: ram_en, ram_addr, data, en, last, busy, done.
  - No done pulse is produced for an aborted scan.

## Timing
- start_i_reader is sampled high at edge T (cycle 0). Address k is driven during cycle 1+k.
- Pixel k appears on data_o_reader/en_o_reader during cycle 2+k+RD_LATENCY.
- en_o_reader is high for exactly RAM_DEPTH consecutive cycles. last_o_reader is high in the final one.
- done_o_reader is high in the cycle immediately after last_o_reader.
- busy_o_reader rises in cycle 1 and falls after the done cycle.
- A new start is accepted no earlier than the cycle after done.
- Back-to-back frames: the frame period is RAM_DEPTH+RD_LATENCY+3 cycles.

## Configuration
- Macro: READER_PREAMBLE_EN.
- Defined:
  - en_o_reader is additionally asserted for one preamble cycle immediately before pixel 0, with data_o_reader=0 and last_o_reader=0.
  - en_o_reader is then high for RAM_DEPTH+1 contiguous cycles. This serves consumers that spend their first enabled cycle leaving IDLE without sampling data.
  - All other timings are unchanged: pixel k stays in cycle 2+k+RD_LATENCY, and done follows last.
- Undefined: no preamble; behaviour exactly as above.

## Test plan
- RAM_DEPTH=16, RD_LATENCY=1, RAM[i]=i+3, start pulse at cycle 0:
  - data_o shows 3..18 in cycles 3..18 with en high.
  - last is high only in cycle 18.
  - done is high in cycle 19, then busy goes low.
- RD_LATENCY=3, RAM_DEPTH=16: first pixel appears in cycle 5; en has no gaps; done follows last by one cycle; the address never exceeds 15.
- RAM_DEPTH=10 (non-power-of-two): the address sequence is 0..9 and ram_en is high for exactly 10 cycles; the done count is 1.
- start held high continuously across two frames:
  - The second scan begins in the cycle after done.
  - The start held during busy does not restart or corrupt the first frame.
- rstn_i_reader low at pixel 7 of a 16-pixel scan:
  - Next cycle all outputs are 0 and there is no done pulse.
  - A new start produces a full 16-pixel frame from address 0.
- READER_PREAMBLE_EN defined, RAM_DEPTH=16, RD_LATENCY=1:
  - en is high in cycles 2..18, with data 0 in cycle 2.
  - Pixels 3..18 appear in cycles 3..18.
  - last is high in cycle 18 and done in cycle 19.
